// File: rtl/intra_res_blockser.sv
// Residue block serializer: captures one macroblock of luma/chroma residue and
// streams it to the forward transform as 24 4x4 blocks over valid/ready.
module intra_res_blockser #(
    parameter int MB_NUMBER_BITS = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MB_NUMBER_BITS:0]   mbnumber,
    input  logic [2:0]                mode_luma16x16,
    input  logic [2:0]                mode_chromab8x8,
    input  logic [2:0]                mode_chromar8x8,
    input  logic signed [7:0]         res_luma16x16 [256],
    input  logic signed [7:0]         res_chromab8x8 [64],
    input  logic signed [7:0]         res_chromar8x8 [64],
    output logic                      blk_valid,
    input  logic                      blk_ready,
    output logic signed [7:0]         blk_data [16],
    output logic [1:0]                blk_comp,
    output logic [3:0]                blk_idx,
    output logic [2:0]                blk_mode,
    output logic [MB_NUMBER_BITS:0]   blk_mbnumber,
    output logic                      blk_last
);

    typedef enum logic [1:0] {IDLE, LUMA, CB, CR} state_t;

    state_t state, state_nx;
    logic [3:0] idx, idx_nx;
    logic       capture;

    logic signed [7:0]       luma_q [256];
    logic signed [7:0]       cb_q   [64];
    logic signed [7:0]       cr_q   [64];
    logic [2:0]              mode_l_q, mode_b_q, mode_r_q;
    logic [MB_NUMBER_BITS:0] mb_q;

    // Luma: row = {by, r}, col = {bx, c} within the 16x16 raster.
    function automatic logic [7:0] luma_addr(input logic [3:0] b, input logic [3:0] e);
        return {b[3:2], e[3:2], b[1:0], e[1:0]};
    endfunction

    function automatic logic [5:0] chroma_addr(input logic [1:0] b, input logic [3:0] e);
        return {b[1], e[3:2], b[0], e[1:0]};
    endfunction

    assign in_ready = (state == IDLE);
    assign capture  = (state == IDLE) && in_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= 4'd0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Outside IDLE blk_valid is high, so blk_ready alone marks a transfer.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = LUMA;
                    idx_nx   = 4'd0;
                end
            end
            LUMA: begin
                if (blk_ready) begin
                    if (idx == 4'd15) begin
                        state_nx = CB;
                        idx_nx   = 4'd0;
                    end else begin
                        idx_nx = idx + 4'd1;
                    end
                end
            end
            CB: begin
                if (blk_ready) begin
                    if (idx == 4'd3) begin
                        state_nx = CR;
                        idx_nx   = 4'd0;
                    end else begin
                        idx_nx = idx + 4'd1;
                    end
                end
            end
            CR: begin
                if (blk_ready) begin
                    if (idx == 4'd3) begin
                        state_nx = IDLE;
                        idx_nx   = 4'd0;
                    end else begin
                        idx_nx = idx + 4'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                idx_nx   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            luma_q   <= '{default: '0};
            cb_q     <= '{default: '0};
            cr_q     <= '{default: '0};
            mode_l_q <= 3'd0;
            mode_b_q <= 3'd0;
            mode_r_q <= 3'd0;
            mb_q     <= '0;
        end else if (capture) begin
            luma_q   <= res_luma16x16;
            cb_q     <= res_chromab8x8;
            cr_q     <= res_chromar8x8;
            mode_l_q <= mode_luma16x16;
            mode_b_q <= mode_chromab8x8;
            mode_r_q <= mode_chromar8x8;
            mb_q     <= mbnumber;
        end
    end

    assign blk_valid    = (state != IDLE);
    assign blk_idx      = idx;
    assign blk_mbnumber = mb_q;
    assign blk_last     = (state == CR) && (idx == 4'd3);

    always_comb begin
        blk_comp = 2'd0;
        blk_mode = 3'd0;
        for (int k = 0; k < 16; k++) blk_data[k] = '0;
        case (state)
            LUMA: begin
                blk_mode = mode_l_q;
                for (int k = 0; k < 16; k++) blk_data[k] = luma_q[luma_addr(idx, 4'(k))];
            end
            CB: begin
                blk_comp = 2'd1;
                blk_mode = mode_b_q;
                for (int k = 0; k < 16; k++) blk_data[k] = cb_q[chroma_addr(idx[1:0], 4'(k))];
            end
            CR: begin
                blk_comp = 2'd2;
                blk_mode = mode_r_q;
                for (int k = 0; k < 16; k++) blk_data[k] = cr_q[chroma_addr(idx[1:0], 4'(k))];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intra_res_blockser.sv
// Directed/random bench for intra_res_blockser against a block-order reference model.
module tb_intra_res_blockser;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [12:0]       mbnumber;
    logic [2:0]        mode_l, mode_b, mode_r;
    logic signed [7:0] luma [256];
    logic signed [7:0] cb [64];
    logic signed [7:0] cr [64];
    logic              blk_valid;
    logic              blk_ready;
    logic signed [7:0] blk_data [16];
    logic [1:0]        blk_comp;
    logic [3:0]        blk_idx;
    logic [2:0]        blk_mode;
    logic [12:0]       blk_mbnumber;
    logic              blk_last;

    int n_checks = 0;
    int n_fails  = 0;

    logic [127:0] exp_data [24];
    logic [1:0]   exp_comp [24];
    logic [3:0]   exp_idx  [24];
    logic [2:0]   exp_mode [24];
    logic         exp_last [24];
    logic [12:0]  exp_mb;
    int           first_el [24];

    intra_res_blockser #(.MB_NUMBER_BITS(12)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mbnumber(mbnumber), .mode_luma16x16(mode_l), .mode_chromab8x8(mode_b),
        .mode_chromar8x8(mode_r), .res_luma16x16(luma), .res_chromab8x8(cb),
        .res_chromar8x8(cr), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .blk_data(blk_data), .blk_comp(blk_comp), .blk_idx(blk_idx),
        .blk_mode(blk_mode), .blk_mbnumber(blk_mbnumber), .blk_last(blk_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] pack_out();
        logic [127:0] v;
        for (int k = 0; k < 16; k++) v[k*8 +: 8] = blk_data[k];
        return v;
    endfunction

    // Reference: 16 luma blocks in raster order, then 4 Cb, then 4 Cr.
    task automatic build_exp();
        for (int n = 0; n < 24; n++) begin
            int b, bx, by;
            if (n < 16) begin
                b = n; bx = b % 4; by = b / 4;
                exp_comp[n] = 2'd0; exp_mode[n] = mode_l;
            end else begin
                b = (n - 16) % 4; bx = b % 2; by = b / 2;
                exp_comp[n] = (n < 20) ? 2'd1 : 2'd2;
                exp_mode[n] = (n < 20) ? mode_b : mode_r;
            end
            exp_idx[n]  = 4'(b);
            exp_last[n] = (n == 23);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    logic signed [7:0] v;
                    if (n < 16)      v = luma[(4*by + r)*16 + 4*bx + c];
                    else if (n < 20) v = cb[(4*by + r)*8 + 4*bx + c];
                    else             v = cr[(4*by + r)*8 + 4*bx + c];
                    exp_data[n][(r*4 + c)*8 +: 8] = v;
                end
        end
        exp_mb = mbnumber;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 256; i++) luma[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) begin cb[i] = 8'($urandom); cr[i] = 8'($urandom); end
        mode_l = 3'($urandom); mode_b = 3'($urandom); mode_r = 3'($urandom);
        mbnumber = 13'($urandom);
    endtask

    task automatic fill_const(input logic signed [7:0] v);
        for (int i = 0; i < 256; i++) luma[i] = v;
        for (int i = 0; i < 64; i++) begin cb[i] = v; cr[i] = v; end
    endtask

    // Called at a negedge with in_ready expected high; returns one cycle later.
    task automatic capture(input bit keep_valid);
        chk("cap_in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        build_exp();
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic stream(input int limit, input bit rnd, input string tag);
        int n = 0;
        int cyc = 0;
        while (n < limit && cyc < 600) begin
            blk_ready = rnd ? (($urandom_range(0, 2) != 0) && cyc != 0) : 1'b1;
            chk({tag, "_valid"}, blk_valid, 1'b1);
            if (!blk_valid) break;
            chk({tag, "_data"}, pack_out(), exp_data[n]);
            chk({tag, "_comp"}, blk_comp, exp_comp[n]);
            chk({tag, "_idx"},  blk_idx,  exp_idx[n]);
            chk({tag, "_mode"}, blk_mode, exp_mode[n]);
            chk({tag, "_mb"},   blk_mbnumber, exp_mb);
            chk({tag, "_last"}, blk_last, exp_last[n]);
            first_el[n] = int'(blk_data[0]);
            if (blk_ready) n++;
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_count"}, n, limit);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_valid"}, blk_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b1; blk_ready = 1'b0;
        fill_rand();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", blk_valid, 1'b0);
            chk("rst_data", pack_out(), 128'd0);
            chk("rst_comp", blk_comp, 2'd0);
            chk("rst_idx", blk_idx, 4'd0);
            chk("rst_mode", blk_mode, 3'd0);
            chk("rst_mb", blk_mbnumber, 13'd0);
            chk("rst_last", blk_last, 1'b0);
            @(negedge clk);
        end
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        // Ramp macroblock, ready held high
        for (int i = 0; i < 256; i++) luma[i] = 8'(i - 128);
        for (int i = 0; i < 64; i++) begin cb[i] = 8'(i); cr[i] = 8'(-i); end
        mode_l = 3'd2; mode_b = 3'd1; mode_r = 3'd0; mbnumber = 13'd37;
        capture(1'b0);
        stream(24, 1'b0, "ramp");
        chk("ramp_blk5_el0", first_el[5], -60);
        chk("ramp_cb3_el0", first_el[19], 36);
        chk("ramp_cr1_el0", first_el[21], -4);
        check_idle("ramp_end");

        // Random residues under random backpressure
        for (int t = 0; t < 3; t++) begin
            fill_rand();
            capture(1'b0);
            stream(24, 1'b1, "bp");
            check_idle("bp_end");
        end

        // Capture isolation with in_valid held high
        fill_rand();
        capture(1'b1);
        fill_rand();
        stream(24, 1'b0, "iso");
        check_idle("iso_gap");
        build_exp();
        @(negedge clk);
        in_valid = 1'b0;
        stream(24, 1'b1, "iso2");
        check_idle("iso2_end");

        // Mid-stream reset after 10 luma transfers
        fill_rand();
        capture(1'b0);
        stream(10, 1'b0, "mid");
        chk("mid_idx10", blk_idx, 4'd10);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", blk_valid, 1'b0);
        chk("mid_rst_idx", blk_idx, 4'd0);
        reset = 1'b1;
        @(negedge clk);
        check_idle("mid_after");
        fill_rand();
        capture(1'b0);
        stream(24, 1'b0, "mid_new");

        // Extremes
        fill_const(-8'sd128);
        capture(1'b0);
        stream(24, 1'b1, "neg");
        chk("neg_el0", first_el[0], -128);
        fill_const(8'sd127);
        capture(1'b0);
        stream(24, 1'b1, "pos");
        chk("pos_el0", first_el[23], 127);
        check_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
